// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants and types shared by the instruction-fetch stage.
//   XLEN             - architectural word width
//   DEFAULT_RESET_PC - default first PC fetched after reset
//   fetch_entry_t    - one buffered fetch result {pc, ir}
//   word_align()     - clears the byte-offset bits of an address
package fetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO holding fetched {pc, ir} entries.
//   clk, reset  - clock and synchronous active-high reset
//   push        - write push_data at the tail (ignored when full)
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the FIFO; overrides a simultaneous push/pop
//   count       - number of valid entries
//   head_data   - entry at the head (stale when empty)
//   full, empty - occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_data = mem[rd_ptr[PW-1:0]];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is cleared on reset only because the head entry is
      // visible on out_ir/out_pc, which must read zero after reset; a flush
      // just moves the read pointer and leaves the array alone.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a decoupling queue.
// Owns the fetch PC, reads a synchronous ROM (one-cycle latency) and buffers
// fetched words in fetch_fifo, presenting them to decode via valid/ready.
//   clk, reset      - clock and synchronous active-high reset
//   redirect_valid  - redirect request from execute (one cycle per request)
//   redirect_pc     - redirect target, low two bits ignored
//   out_valid       - head entry valid
//   out_ready       - decode accepts the head this cycle
//   out_ir, out_pc  - instruction word at the head and its PC
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              MEM_WORDS = 16384,
  parameter int              QDEPTH    = 4,
  parameter string           INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ir,
  output logic [XLEN-1:0] out_pc
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(QDEPTH);

  logic [XLEN-1:0] rom [MEM_WORDS];

  logic [XLEN-1:0] fpc;
  logic            iss_valid;
  logic [XLEN-1:0] iss_pc;
  logic [XLEN-1:0] rom_q;
  logic            ret_valid;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] ret_ir;
  logic            issue;
  logic            pop;
  logic [CW:0]     count;
  logic [CW+1:0]   in_use;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign pop = out_valid && out_ready;

  // Credit: every word already queued or still in flight owns a FIFO slot,
  // and a pop on this edge frees one, so the FIFO can never overflow.
  assign in_use = (CW+2)'(count) + (CW+2)'(iss_valid) + (CW+2)'(ret_valid);
  assign issue  = !reset && !redirect_valid && (int'(in_use) < QDEPTH + int'(pop));

  // Synchronous ROM read; out-of-range PCs wrap through the truncated index.
  always_ff @(posedge clk) begin
    if (issue) rom_q <= rom[fpc[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc       <= RESET_PC;
      iss_valid <= 1'b0;
      iss_pc    <= '0;
      ret_valid <= 1'b0;
      ret_pc    <= '0;
      ret_ir    <= '0;
    end else if (redirect_valid) begin
      fpc       <= word_align(redirect_pc);
      iss_valid <= 1'b0;
      ret_valid <= 1'b0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        iss_pc <= fpc;
        fpc    <= fpc + 32'd4;
      end
      ret_valid <= iss_valid;
      ret_pc    <= iss_pc;
      ret_ir    <= rom_q;
    end
  end

  assign push_entry = '{pc: ret_pc, ir: ret_ir};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_valid),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .count     (count),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head_entry.pc;
  assign out_ir    = head_entry.ir;

  // The credit rule guarantees a returning word always finds a free slot.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid) assert (!(ret_valid && fifo_full && !pop));
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// The reference model is the architectural instruction stream: after a reset
// or redirect the delivered PCs must run target, target+4, ... with the ROM
// word at each PC, the first word must appear exactly 3 edges after the
// restart edge, and once primed a QDEPTH>=4 queue never runs dry.
module tb_fetch_queue;

  localparam int          MW  = 64;
  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .RESET_PC  (RPC),
    .MEM_WORDS (MW),
    .QDEPTH    (QD),
    .INIT_FILE ("")
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_pc         (out_pc)
  );

  logic [31:0] rom_model [MW];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          delivered = 0;
  logic [31:0] exp_pc;
  int          since;
  bit          hold;
  logic [31:0] held_pc;
  logic [31:0] held_ir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rom_at(input logic [31:0] pc);
    return rom_model[int'((pc >> 2) % 32'(MW))];
  endfunction

  // One cycle: drive inputs at the falling edge, check outputs, update the
  // model for what the coming rising edge does, then advance.
  task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rst);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #1;
    if (since < 3) check("idle_after_restart", {31'b0, out_valid}, 32'd0);
    else           check("queue_primed", {31'b0, out_valid}, 32'd1);
    if (hold) begin
      check("hold_pc", out_pc, held_pc);
      check("hold_ir", out_ir, held_ir);
    end
    if (out_valid && rdy) begin
      check("out_pc", out_pc, exp_pc);
      check("out_ir", out_ir, rom_at(exp_pc));
      exp_pc += 32'd4;
      delivered++;
    end
    hold    = out_valid && !rdy && !rv && !rst;
    held_pc = out_pc;
    held_ir = out_ir;
    if (rst) begin
      exp_pc = RPC;
      since  = 0;
    end else if (rv) begin
      exp_pc = rpc & ~32'h3;
      since  = 0;
    end else if (since < 1000) begin
      since++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      rom_model[i] = 32'h100 + 32'(i);
      dut.rom[i]   = 32'h100 + 32'(i);
    end
    exp_pc = RPC;
    since  = 0;
    hold   = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_ir", out_ir, 32'h0);

    // Streaming from reset with out_ready high
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    run(10, 1'b1);

    // Stall 10 cycles after the first valid, then resume
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    run(3, 1'b1);
    run(10, 1'b0);
    run(10, 1'b1);

    // Redirect to 0x40 while the queue holds 0x8..0x14
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    run(5, 1'b1);
    run(6, 1'b0);
    tick(1'b0, 1'b1, 32'h40, 1'b0);
    run(8, 1'b1);

    // Redirect on the same edge as the transfer of pc 0x8
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    run(5, 1'b1);
    tick(1'b1, 1'b1, 32'h20, 1'b0);
    run(6, 1'b1);

    // Back-to-back redirects: last one wins
    tick(1'b1, 1'b1, 32'h33, 1'b0);
    tick(1'b1, 1'b1, 32'h80, 1'b0);
    run(8, 1'b1);

    // PC wrap past 32'hFFFF_FFFC
    tick(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    run(8, 1'b1);

    // Reset with a full queue and out_ready low
    run(10, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("midreset_pc", out_pc, 32'h0);
    check("midreset_ir", out_ir, 32'h0);
    run(6, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          r_rdy;
      bit          r_rv;
      bit          r_rst;
      logic [31:0] r_pc;
      r_rdy = ($urandom % 4) != 0;
      r_rv  = ($urandom % 20) == 0;
      r_rst = ($urandom % 150) == 0;
      r_pc  = $urandom;
      tick(r_rdy, r_rv, r_pc, r_rst);
    end
    run(6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
